pin_input_cond: RTL
===================

PIN_INPUT_COND -- requirements
Module: pin_input_cond

Interface
REQ-001 The parameter DEBOUNCE_CYCLES SHALL default to 500000 and set the stable-cycle count needed to accept an input change (10 ms at 50 MHz); legal range is 1 or more.
REQ-002 The parameter REPEAT_DELAY SHALL default to 25000000 and set the cycles from key_press to the first key_repeat; legal range is 2 or more.
REQ-003 The parameter REPEAT_PERIOD SHALL default to 5000000 and set the cycles between successive key_repeat pulses; legal range is 1 or more.
REQ-004 max10_clk1_50  in  1  sole clock, rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 key  in  2  raw pushbuttons, asynchronous, active-low (0 = pressed).
REQ-007 sw  in  10  raw slide switches, asynchronous, active-high.
REQ-008 key_level  out  2  debounced key state, active-high (1 = pressed).
REQ-009 key_press  out  2  one-cycle pulse per bit when key_level rises.
REQ-010 key_release  out  2  one-cycle pulse per bit when key_level falls.
REQ-011 key_repeat  out  2  one-cycle auto-repeat pulse per bit while the key is held.
REQ-012 sw_level  out  10  debounced switch state.
REQ-013 sw_change  out  1  one-cycle pulse when any sw_level bit changes.

Function
REQ-014 Each key and sw bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-015 Each bit SHALL have its own debounce counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-016 A bit's counter SHALL clear on every cycle the synchronized value equals the debounced level.
REQ-017 A bit's counter SHALL increment on every cycle the synchronized value differs from the debounced level.
REQ-018 When the counter reaches DEBOUNCE_CYCLES, the debounced level SHALL toggle and the counter SHALL clear.
REQ-019 For a raw input held constant, the debounced output SHALL change on the (DEBOUNCE_CYCLES+2)th rising edge after the raw change.
REQ-020 Registered outputs SHALL be used throughout: key_press, key_release and sw_change SHALL assert in the same cycle as the corresponding level transition and deassert one cycle later.
REQ-021 sw_change SHALL be a single pulse even when several sw_level bits change in the same cycle.
REQ-022 Each key SHALL have an independent repeat FSM with states IDLE, DELAY and REPEAT, plus one counter of width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)).
REQ-023 IDLE -> DELAY SHALL occur on key_press, with the counter cleared.
REQ-024 DELAY -> REPEAT SHALL occur when the counter reaches REPEAT_DELAY-1; key_repeat pulses in that cycle and the counter clears.
REQ-025 In REPEAT, when the counter reaches REPEAT_PERIOD-1, key_repeat SHALL pulse and the counter SHALL clear; the FSM stays in REPEAT.
REQ-026 The first key_repeat SHALL occur REPEAT_DELAY cycles after key_press, and later pulses SHALL occur every REPEAT_PERIOD cycles.
REQ-027 DELAY or REPEAT -> IDLE SHALL occur in the cycle key_level falls, with the counter cleared.
REQ-028 If a release and a due repeat coincide, the release SHALL win: key_repeat stays 0 in that cycle.
REQ-029 key_repeat SHALL never assert in the same cycle as key_press.
REQ-030 Both keys SHALL operate fully independently, including simultaneous presses.
REQ-031 Counters SHALL saturate and never wrap.

Reset
REQ-032 While reset_n=0, all outputs SHALL be 0, all FSMs SHALL be IDLE and all counters SHALL be 0.
REQ-033 While reset_n=0, key synchronizer flops SHALL hold 1 (released) and sw synchronizer flops SHALL hold 0.
REQ-034 Reset SHALL take effect asynchronously, including mid-debounce and mid-repeat, and SHALL release synchronously through the normal path.
REQ-035 A key held through reset SHALL produce key_press DEBOUNCE_CYCLES+2 cycles after reset_n rises.
REQ-036 A switch that is 1 through reset SHALL produce sw_change DEBOUNCE_CYCLES+2 cycles after reset_n rises.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-037 Press test: drive key[0] 1->0 and hold -> key_level[0]=1 at edge 6, key_press[0]=1 for exactly one cycle, key[1] outputs stay 0.
REQ-038 Bounce test: toggle key[0] every 2 cycles for 20 cycles, then hold 1 -> no key_level, key_press or key_release activity.
REQ-039 Repeat test: hold key[0] for 20 cycles past key_press, then release -> key_repeat[0] at +10, +13, +16, +19; key_release[0] six cycles after the raw release; no repeat afterwards.
REQ-040 Coincidence test: time the release so key_level falls on a due repeat cycle -> key_release=1 and key_repeat=0 in that cycle.
REQ-041 Switch test: drive sw[3] and sw[7] 0->1 on the same edge -> sw_level=10'h088 at edge 6 and a single sw_change pulse.
REQ-042 Reset test: assert reset_n=0 during REPEAT -> all outputs 0 immediately; release with key[0] still 0 -> key_press at edge 6, then the repeat sequence restarts from DELAY.

Source files
------------

// File: rtl/pin_input_cond.sv
// rtl/pin_input_cond.sv - debounced pushbutton/switch conditioning with key auto-repeat

// Per-bit debouncer: a two-flop synchronizer followed by a stable-count filter.
// The *_evt outputs are combinational and fire on the edge where level toggles.
module pin_input_cond_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit SYNC_INIT       = 1'b0,
  parameter bit INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  // Toggling when the count already holds DEBOUNCE_CYCLES-1 means the level
  // changes on the same edge the count would reach DEBOUNCE_CYCLES.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          sample;
  logic          differ;
  logic          expire;

  assign sample   = sync_q[1] ^ INVERT;
  assign differ   = (sample != level);
  assign expire   = differ && (cnt_q >= CNT_LAST);
  assign rise_evt = expire && sample;
  assign fall_evt = expire && !sample;

  // Two-flop synchronizer; the reset value is the input's idle state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{SYNC_INIT}};
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  // Stable-count filter: clear while matching, count while different, saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!differ || expire) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Debounced level follows the synchronized input once it has been stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
    end else if (expire) begin
      level <= sample;
    end
  end

endmodule

// Per-key auto-repeat engine: IDLE -> DELAY on press, DELAY -> REPEAT after the
// initial delay, periodic pulses in REPEAT, back to IDLE on release.
module pin_input_cond_repeat #(
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic press_evt,
  input  logic release_evt,
  output logic repeat_pulse
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] CNT_MAX     = {RW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rep_state_t;

  rep_state_t    state_q, state_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          rep_d;

  // State, counter and registered repeat pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      repeat_pulse <= rep_d;
    end
  end

  // Next-state logic; a release always takes priority over a due repeat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (press_evt) begin
          state_d = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (release_evt) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DELAY_LAST) begin
          state_d = ST_REPEAT;
          cnt_d   = '0;
          rep_d   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (release_evt) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= PERIOD_LAST) begin
          cnt_d = '0;
          rep_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// Top level: two active-low keys with press/release/repeat and ten switches
// with a combined change strobe.
module pin_input_cond #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       max10_clk1_50,
  input  logic       reset_n,
  input  logic [1:0] key,
  input  logic [9:0] sw,
  output logic [1:0] key_level,
  output logic [1:0] key_press,
  output logic [1:0] key_release,
  output logic [1:0] key_repeat,
  output logic [9:0] sw_level,
  output logic       sw_change
);

  logic [1:0] key_rise_evt;
  logic [1:0] key_fall_evt;
  logic [9:0] sw_rise_evt;
  logic [9:0] sw_fall_evt;

  for (genvar k = 0; k < 2; k++) begin : g_key
    // Keys idle high, so the synchronizer resets to 1 and the level is inverted.
    pin_input_cond_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_INIT      (1'b1),
      .INVERT         (1'b1)
    ) u_deb (
      .clk     (max10_clk1_50),
      .rst_n   (reset_n),
      .raw     (key[k]),
      .level   (key_level[k]),
      .rise_evt(key_rise_evt[k]),
      .fall_evt(key_fall_evt[k])
    );

    pin_input_cond_repeat #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_rep (
      .clk         (max10_clk1_50),
      .rst_n       (reset_n),
      .press_evt   (key_rise_evt[k]),
      .release_evt (key_fall_evt[k]),
      .repeat_pulse(key_repeat[k])
    );
  end

  for (genvar s = 0; s < 10; s++) begin : g_sw
    pin_input_cond_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_INIT      (1'b0),
      .INVERT         (1'b0)
    ) u_deb (
      .clk     (max10_clk1_50),
      .rst_n   (reset_n),
      .raw     (sw[s]),
      .level   (sw_level[s]),
      .rise_evt(sw_rise_evt[s]),
      .fall_evt(sw_fall_evt[s])
    );
  end

  // Edge strobes registered on the same edge the debounced levels change.
  always_ff @(posedge max10_clk1_50 or negedge reset_n) begin
    if (!reset_n) begin
      key_press   <= '0;
      key_release <= '0;
      sw_change   <= 1'b0;
    end else begin
      key_press   <= key_rise_evt;
      key_release <= key_fall_evt;
      sw_change   <= |(sw_rise_evt | sw_fall_evt);
    end
  end

endmodule
